// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
// Latency: none (definitions only).
// Backpressure: not applicable.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  // Arbiter FSM: IDLE picks a requester, GRANT steers its handshake.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Next requester index after s, wrapping 3 -> 0.
  function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
    return s + SEL_W'(1);
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Rotate-priority picker: first set request bit at or after ptr, wrapping 3 -> 0.
// Latency: purely combinational.
// Backpressure: none; any_req_o is simply the OR of all requests.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [SEL_W-1:0]   idx_o,
  output logic               any_req_o
);

  logic [SEL_W-1:0] cand;

  // Walk the candidates from lowest to highest priority so the last hit,
  // i.e. the one closest to ptr, is the one that sticks.
  always_comb begin
    idx_o = ptr_i;
    cand  = ptr_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr_i + SEL_W'(k);
      if (req_i[cand]) begin
        idx_o = cand;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 muxed valid/ready channel between four requesters.
// Latency: 1 cycle of arbitration (IDLE) per grant; data path is combinational.
// Backpressure: out_ready is steered to the granted requester only; the grant is held until it transfers.
// Optional packet lock is enabled with `define MUX_ARB_LOCK_EN (grant held until last / MAX_BEATS).
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         sel,
  output logic                     grant_valid
);

  arb_state_e       state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] sel_q;
  logic             grant_valid_q;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             xfer;
  logic             grant_end;

  logic [WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
  end

  rr_pick4 u_pick (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .idx_o     (pick_idx),
    .any_req_o (pick_any)
  );

  // Steer the granted requester onto the output; everything is quiet in IDLE.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    req_ready = '0;
    if (state_q == GRANT) begin
      out_valid        = req_valid[sel_q];
      out_data         = data_arr[sel_q];
      out_last         = req_last[sel_q];
      req_ready[sel_q] = out_ready;
    end
  end

  assign xfer = out_valid && out_ready;

`ifdef MUX_ARB_LOCK_EN
  // Counter wide enough to hold MAX_BEATS itself; one bit when the limit is off.
  localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;

  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W:0]   beat_inc;
  logic             hit_max;

  assign beat_inc  = {1'b0, beat_cnt_q} + (CNT_W + 1)'(1);
  assign hit_max   = (MAX_BEATS != 0) && (beat_inc == (CNT_W + 1)'(MAX_BEATS));
  assign grant_end = xfer && (out_last || hit_max);
`else
  // Single-beat arbitration: every accepted beat hands the channel on.
  logic unused_max_beats;
  assign unused_max_beats = |MAX_BEATS;
  assign grant_end        = xfer;
`endif

  // Arbitration FSM with registered sel / grant_valid and the rotating pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      sel_q         <= '0;
      grant_valid_q <= 1'b0;
`ifdef MUX_ARB_LOCK_EN
      beat_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            sel_q         <= pick_idx;
            state_q       <= GRANT;
            grant_valid_q <= 1'b1;
`ifdef MUX_ARB_LOCK_EN
            beat_cnt_q    <= '0;
`endif
          end
        end
        GRANT: begin
`ifdef MUX_ARB_LOCK_EN
          if (xfer) begin
            beat_cnt_q <= beat_inc[CNT_W-1:0];
          end
`endif
          if (grant_end) begin
            // The released requester drops to lowest priority next round.
            ptr_q         <= sel_inc(sel_q);
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign sel         = sel_q;
  assign grant_valid = grant_valid_q;

  // At most one requester ever sees ready.
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

  // A grant never moves to another requester without an intervening release.
  a_sel_stable: assert property (@(posedge clk) disable iff (rst)
    (grant_valid_q && !grant_end) |=> (sel_q == $past(sel_q)));

  // grant_valid mirrors the FSM state.
  a_gv_state: assert property (@(posedge clk) disable iff (rst)
    grant_valid_q == (state_q == GRANT));

endmodule
